// File: rtl/sound_sequencer.sv
// Prioritised game-event beep sequencer: plays a square-wave beep pattern per event
// request, with higher-priority preemption and a one-deep pending slot.
module sound_sequencer #(
  parameter int N_EVT     = 6,
  parameter int IDW       = 3,
  parameter int HPW       = 16,
  parameter int HP_BASE   = 28409,
  parameter int HP_STEP   = 2000,
  parameter int BEEPS     = 2,
  parameter int ON_TICKS  = 4,
  parameter int OFF_TICKS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slowen,
  input  logic [N_EVT-1:0] evt,
  input  logic             gain_sel,
  input  logic             mute,
  output logic             audio,
  output logic             gain,
  output logic             notshutdown,
  output logic             busy,
  output logic [IDW-1:0]   cur_evt,
  output logic             pend_valid
);

  localparam int MAXT = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TW   = $clog2(MAXT + 1);
  localparam int BW   = $clog2(BEEPS + 1);

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] cur_q, cur_d;
  logic [IDW-1:0] pend_idx_q, pend_idx_d;
  logic           pend_valid_q, pend_valid_d;
  logic [HPW-1:0] hp_cnt_q, hp_cnt_d;
  logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]  beep_cnt_q, beep_cnt_d;
  logic           tone_q, tone_d;
  logic           gain_q, gain_d;
  logic           audio_q, notshutdown_q;

  logic [HPW-1:0] hp_last;
  logic [IDW-1:0] win;
  logic           req;
  logic           done;
  logic           do_load;
  logic [IDW-1:0] load_idx;

  // Highest set bit of evt wins.
  always_comb begin
    win = '0;
    for (int i = 0; i < N_EVT; i++) begin
      if (evt[i]) win = IDW'(i);
    end
  end

  assign req     = |evt;
  assign hp_last = HPW'(HP_BASE - HP_STEP * int'(cur_q) - 1);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    cur_d        = cur_q;
    pend_idx_d   = pend_idx_q;
    pend_valid_d = pend_valid_q;
    hp_cnt_d     = hp_cnt_q;
    tick_cnt_d   = tick_cnt_q;
    beep_cnt_d   = beep_cnt_q;
    tone_d       = tone_q;
    gain_d       = gain_q;
    done         = 1'b0;
    do_load      = 1'b0;
    load_idx     = win;

    unique case (state_q)
      IDLE: tone_d = 1'b0;
      ON: begin
        hp_cnt_d = hp_cnt_q + 1'b1;
        if (hp_cnt_q == hp_last) begin
          tone_d   = ~tone_q;
          hp_cnt_d = '0;
        end
        // Leaving ON forces silence even if a toggle was due this cycle.
        if (slowen) begin
          if (tick_cnt_q == TW'(ON_TICKS - 1)) begin
            tone_d     = 1'b0;
            tick_cnt_d = '0;
            hp_cnt_d   = '0;
            state_d    = OFF;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      OFF: begin
        tone_d = 1'b0;
        if (slowen) begin
          if (tick_cnt_q == TW'(OFF_TICKS - 1)) begin
            tick_cnt_d = '0;
            if (beep_cnt_q == BW'(BEEPS - 1)) begin
              done = 1'b1;
            end else begin
              beep_cnt_d = beep_cnt_q + 1'b1;
              state_d    = ON;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A completing pattern arbitrates like IDLE: a new winner beats an equal-or-lower pending.
    if (state_q == IDLE || done) begin
      if (req && (!pend_valid_q || win > pend_idx_q)) begin
        do_load = 1'b1;
      end else if (pend_valid_q) begin
        do_load      = 1'b1;
        load_idx     = pend_idx_q;
        pend_valid_d = 1'b0;
        if (req && win < pend_idx_q) begin
          pend_idx_d   = win;
          pend_valid_d = 1'b1;
        end
      end else begin
        state_d = IDLE;
      end
    end else if (req) begin
      if (win > cur_q) begin
        do_load = 1'b1;
      end else if (win < cur_q && (!pend_valid_q || win > pend_idx_q)) begin
        pend_idx_d   = win;
        pend_valid_d = 1'b1;
      end
    end

    if (do_load) begin
      cur_d      = load_idx;
      hp_cnt_d   = '0;
      tick_cnt_d = '0;
      beep_cnt_d = '0;
      gain_d     = gain_sel;
      tone_d     = 1'b0;
      state_d    = ON;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; reset is synchronous and active-low.
    if (!rst) begin
      state_q       <= IDLE;
      cur_q         <= '0;
      pend_idx_q    <= '0;
      pend_valid_q  <= 1'b0;
      hp_cnt_q      <= '0;
      tick_cnt_q    <= '0;
      beep_cnt_q    <= '0;
      tone_q        <= 1'b0;
      gain_q        <= 1'b0;
      audio_q       <= 1'b0;
      notshutdown_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      pend_idx_q    <= pend_idx_d;
      pend_valid_q  <= pend_valid_d;
      hp_cnt_q      <= hp_cnt_d;
      tick_cnt_q    <= tick_cnt_d;
      beep_cnt_q    <= beep_cnt_d;
      tone_q        <= tone_d;
      gain_q        <= gain_d;
      // Mute gates only the amplifier-facing outputs; the tone keeps its phase.
      audio_q       <= tone_d & ~mute;
      notshutdown_q <= (state_d != IDLE) & ~mute;
    end
  end

  assign audio       = audio_q;
  assign gain        = gain_q;
  assign notshutdown = notshutdown_q;
  assign busy        = (state_q != IDLE);
  assign cur_evt     = cur_q;
  assign pend_valid  = pend_valid_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Self-checking bench for sound_sequencer: directed scenarios then random traffic,
// every cycle compared against a behavioural pattern model.
module tb_sound_sequencer;

  localparam int N_EVT     = 4;
  localparam int IDW       = 2;
  localparam int HPW       = 16;
  localparam int HP_BASE   = 8;
  localparam int HP_STEP   = 2;
  localparam int BEEPS     = 2;
  localparam int ON_TICKS  = 3;
  localparam int OFF_TICKS = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             slowen = 1'b0;
  logic [N_EVT-1:0] evt = '0;
  logic             gain_sel = 1'b0;
  logic             mute = 1'b0;
  logic             audio, gain, notshutdown, busy, pend_valid;
  logic [IDW-1:0]   cur_evt;

  int checks = 0;
  int errors = 0;
  int slow_cnt = 0;

  // Behavioural model: a pattern is "playing" with a current beep, an on/off phase,
  // slowen ticks seen in that phase and clocks elapsed since the tone phase began.
  bit m_busy, m_off, m_gain, m_mute;
  int m_cur, m_pend, m_beep, m_ticks, m_on_clk;

  sound_sequencer #(
    .N_EVT(N_EVT), .IDW(IDW), .HPW(HPW), .HP_BASE(HP_BASE), .HP_STEP(HP_STEP),
    .BEEPS(BEEPS), .ON_TICKS(ON_TICKS), .OFF_TICKS(OFF_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .slowen(slowen), .evt(evt), .gain_sel(gain_sel), .mute(mute),
    .audio(audio), .gain(gain), .notshutdown(notshutdown), .busy(busy),
    .cur_evt(cur_evt), .pend_valid(pend_valid)
  );

  always #5 clk = ~clk;

  function automatic int winner(input logic [N_EVT-1:0] e);
    for (int i = N_EVT - 1; i >= 0; i--) if (e[i]) return i;
    return -1;
  endfunction

  task automatic start(input int idx);
    m_busy = 1; m_cur = idx; m_off = 0; m_ticks = 0; m_beep = 0; m_on_clk = 0;
    m_gain = gain_sel;
  endtask

  task automatic model_step();
    int  w;
    int  p;
    bit  finished;
    m_mute = mute;
    if (!rst) begin
      m_busy = 0; m_off = 0; m_gain = 0; m_cur = 0; m_pend = -1;
      m_beep = 0; m_ticks = 0; m_on_clk = 0;
      return;
    end
    w = winner(evt);
    finished = 0;
    if (m_busy) begin
      if (!m_off) begin
        m_on_clk++;
        if (slowen) begin
          m_ticks++;
          if (m_ticks == ON_TICKS) begin m_off = 1; m_ticks = 0; end
        end
      end else if (slowen) begin
        m_ticks++;
        if (m_ticks == OFF_TICKS) begin
          m_ticks = 0;
          if (m_beep == BEEPS - 1) finished = 1;
          else begin m_beep++; m_off = 0; m_on_clk = 0; end
        end
      end
    end
    if (!m_busy || finished) begin
      if (finished) m_busy = 0;
      if (w >= 0 && (m_pend < 0 || w > m_pend)) start(w);
      else if (m_pend >= 0) begin
        p = m_pend; m_pend = -1; start(p);
        if (w >= 0 && w < p) m_pend = w;
      end
    end else if (w >= 0) begin
      if (w > m_cur) start(w);
      else if (w < m_cur && (m_pend < 0 || w > m_pend)) m_pend = w;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare();
    int  hp;
    bit  tone;
    hp   = HP_BASE - m_cur * HP_STEP;
    tone = m_busy && !m_off && (((m_on_clk / hp) % 2) == 1);
    check("busy",        32'(busy),        32'(m_busy));
    check("cur_evt",     32'(cur_evt),     32'(m_cur));
    check("pend_valid",  32'(pend_valid),  32'(m_pend >= 0));
    check("gain",        32'(gain),        32'(m_gain));
    check("audio",       32'(audio),       32'(tone && !m_mute));
    check("notshutdown", 32'(notshutdown), 32'(m_busy && !m_mute));
  endtask

  // One clock: inputs are already set; model and DUT see the same edge, outputs compared 1 time unit later.
  task automatic step();
    slowen = (slow_cnt == 3);
    @(posedge clk);
    model_step();
    slow_cnt = (slow_cnt + 1) % 4;
    #1;
    compare();
    evt = '0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    m_pend = -1;

    // 1: reset with all requests asserted
    rst = 1'b0; evt = 4'b1111; step();
    evt = 4'b1111; step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_audio", 32'(audio), 32'd0);
    rst = 1'b1;
    run(5);
    check("idle_after_rst", 32'(busy), 32'd0);

    // 2: single lowest-priority pattern
    evt = 4'b0001; step();
    check("evt0_busy", 32'(busy), 32'd1);
    run(8);
    check("evt0_first_rise", 32'(audio), 32'd1);
    run(50);
    check("evt0_done", 32'(busy), 32'd0);

    // 3: preemption by a higher event
    evt = 4'b0001; step();
    run(10);
    evt = 4'b0010; step();
    check("preempt_cur", 32'(cur_evt), 32'd1);
    check("preempt_pend", 32'(pend_valid), 32'd0);
    run(50);

    // 4: lower requests queue behind the top event
    evt = 4'b1000; step();
    run(3);
    evt = 4'b0001; step();
    run(2);
    evt = 4'b0100; step();
    check("pend_set", 32'(pend_valid), 32'd1);
    run(90);

    // 5: multiple bits in IDLE, gain latched at start
    gain_sel = 1'b1; evt = 4'b0110; step();
    check("multi_cur", 32'(cur_evt), 32'd2);
    run(10);
    gain_sel = 1'b0;
    run(15);
    check("gain_held", 32'(gain), 32'd1);
    run(30);

    // 6: mute mid-tone
    evt = 4'b0001; step();
    run(10);
    mute = 1'b1; step();
    check("mute_audio", 32'(audio), 32'd0);
    check("mute_ns", 32'(notshutdown), 32'd0);
    check("mute_busy", 32'(busy), 32'd1);
    run(6);
    mute = 1'b0;
    run(40);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      rst      = ($urandom_range(399) != 0);
      evt      = ($urandom_range(11) == 0) ? N_EVT'($urandom_range(15, 1)) : '0;
      gain_sel = 1'($urandom);
      if ($urandom_range(29) == 0) mute = ~mute;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
